// File: rtl/decode_stage.sv
// Decode stage of the 16-bit pipelined RISC core: instruction decode,
// 8-entry register file with write-through bypass, two-word LDM handling,
// and the registered ID/EX operand/control slot with stall and flush.
module decode_stage #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              instr,
    input  logic                     instr_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    output logic [DATA_W-1:0]        Op1,
    output logic [DATA_W-1:0]        Op2,
    output logic [1:0]               ALUmode,
    output logic [1:0]               carrySelect,
    output logic [2:0]               dest_r,
    output logic                     reg_write_r,
    output logic                     valid_r,
    output logic                     illegal_r
);

    localparam int AW = $clog2(NREGS);

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_SETC = 5'b00001;
    localparam logic [4:0] OP_CLRC = 5'b00010;
    localparam logic [4:0] OP_NOT  = 5'b00011;
    localparam logic [4:0] OP_INC  = 5'b00100;
    localparam logic [4:0] OP_MOV  = 5'b00101;
    localparam logic [4:0] OP_ADD  = 5'b00110;
    localparam logic [4:0] OP_LDM  = 5'b00111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_NOT  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;
    localparam logic [1:0] ALU_NOP  = 2'b11;

    localparam logic [1:0] C_KEEP = 2'b00;
    localparam logic [1:0] C_SET  = 2'b01;
    localparam logic [1:0] C_ALU  = 2'b10;
    localparam logic [1:0] C_CLR  = 2'b11;

    typedef enum logic {OPC, IMM} state_t;

    state_t              state_q, state_d;
    logic [2:0]          ldm_rdst_q, ldm_rdst_d;
    logic [DATA_W-1:0]   rf_q [NREGS];
    logic [DATA_W-1:0]   rf_d [NREGS];

    logic [DATA_W-1:0]   op1_q, op1_d, op2_q, op2_d;
    logic [1:0]          alu_q, alu_d, cs_q, cs_d;
    logic [2:0]          dest_q, dest_d;
    logic                rw_q, rw_d, vld_q, vld_d, ill_q, ill_d;

    logic [4:0]          opcode;
    logic [2:0]          rdst;
    logic [AW-1:0]       rs1, rs2;
    logic [DATA_W-1:0]   rd1, rd2;
    logic                unused_low_bits;

    assign opcode          = instr[15:11];
    assign rdst            = instr[10:8];
    assign rs1             = AW'(instr[7:5]);
    assign rs2             = AW'(instr[4:2]);
    assign unused_low_bits = ^instr[1:0];

    // Register file reads with same-cycle writeback bypass
    always_comb begin
        rd1 = (wb_en && wb_addr == rs1) ? wb_data : rf_q[rs1];
        rd2 = (wb_en && wb_addr == rs2) ? wb_data : rf_q[rs2];
    end

    // Writeback path: accepted regardless of stall/flush
    always_comb begin
        rf_d = rf_q;
        if (wb_en) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    // Next ID/EX slot and LDM FSM: flush > stall > normal decode
    always_comb begin
        op1_d      = op1_q;
        op2_d      = op2_q;
        alu_d      = alu_q;
        cs_d       = cs_q;
        dest_d     = dest_q;
        rw_d       = rw_q;
        vld_d      = vld_q;
        ill_d      = ill_q;
        state_d    = state_q;
        ldm_rdst_d = ldm_rdst_q;

        if (flush || !stall) begin
            // Start from a bubble; decode below overrides it
            op1_d  = '0;
            op2_d  = '0;
            alu_d  = ALU_NOP;
            cs_d   = C_KEEP;
            dest_d = '0;
            rw_d   = 1'b0;
            vld_d  = 1'b0;
            ill_d  = 1'b0;
        end

        if (flush) begin
            state_d = OPC;
        end else if (!stall && instr_valid) begin
            if (state_q == IMM) begin
                // Second LDM word: pass the immediate through to the latched Rdst
                op1_d   = instr;
                alu_d   = ALU_PASS;
                dest_d  = ldm_rdst_q;
                rw_d    = 1'b1;
                vld_d   = 1'b1;
                state_d = OPC;
            end else begin
                case (opcode)
                    OP_NOP: begin
                        dest_d = rdst;
                        vld_d  = 1'b1;
                    end
                    OP_SETC: begin
                        cs_d   = C_SET;
                        dest_d = rdst;
                        vld_d  = 1'b1;
                    end
                    OP_CLRC: begin
                        cs_d   = C_CLR;
                        dest_d = rdst;
                        vld_d  = 1'b1;
                    end
                    OP_NOT: begin
                        op1_d  = rd1;
                        alu_d  = ALU_NOT;
                        dest_d = rdst;
                        rw_d   = 1'b1;
                        vld_d  = 1'b1;
                    end
                    OP_INC: begin
                        op1_d  = rd1;
                        op2_d  = DATA_W'(1);
                        alu_d  = ALU_ADD;
                        cs_d   = C_ALU;
                        dest_d = rdst;
                        rw_d   = 1'b1;
                        vld_d  = 1'b1;
                    end
                    OP_MOV: begin
                        op1_d  = rd1;
                        alu_d  = ALU_PASS;
                        dest_d = rdst;
                        rw_d   = 1'b1;
                        vld_d  = 1'b1;
                    end
                    OP_ADD: begin
                        op1_d  = rd1;
                        op2_d  = rd2;
                        alu_d  = ALU_ADD;
                        cs_d   = C_ALU;
                        dest_d = rdst;
                        rw_d   = 1'b1;
                        vld_d  = 1'b1;
                    end
                    OP_LDM: begin
                        ldm_rdst_d = rdst;
                        state_d    = IMM;
                    end
                    default: begin
                        ill_d = 1'b1;
                    end
                endcase
            end
        end
    end

    // State update: reset loads a bubble, clears the register file, returns FSM to OPC
    always_ff @(posedge clk) begin
        if (reset) begin
            op1_q      <= '0;
            op2_q      <= '0;
            alu_q      <= ALU_NOP;
            cs_q       <= C_KEEP;
            dest_q     <= '0;
            rw_q       <= 1'b0;
            vld_q      <= 1'b0;
            ill_q      <= 1'b0;
            state_q    <= OPC;
            ldm_rdst_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            alu_q      <= alu_d;
            cs_q       <= cs_d;
            dest_q     <= dest_d;
            rw_q       <= rw_d;
            vld_q      <= vld_d;
            ill_q      <= ill_d;
            state_q    <= state_d;
            ldm_rdst_q <= ldm_rdst_d;
            rf_q       <= rf_d;
        end
    end

    assign Op1         = op1_q;
    assign Op2         = op2_q;
    assign ALUmode     = alu_q;
    assign carrySelect = cs_q;
    assign dest_r      = dest_q;
    assign reg_write_r = rw_q;
    assign valid_r     = vld_q;
    assign illegal_r   = ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// Table-driven bench for decode_stage with an expected-output scoreboard.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, instr_valid, stall, flush, wb_en;
    logic [15:0] instr, wb_data;
    logic [2:0]  wb_addr;
    logic [15:0] Op1, Op2;
    logic [1:0]  ALUmode, carrySelect;
    logic [2:0]  dest_r;
    logic        reg_write_r, valid_r, illegal_r;

    decode_stage dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .Op1(Op1), .Op2(Op2), .ALUmode(ALUmode),
        .carrySelect(carrySelect), .dest_r(dest_r), .reg_write_r(reg_write_r),
        .valid_r(valid_r), .illegal_r(illegal_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, iv, stl, fl, we;
        logic [2:0]  wa;
        logic [15:0] wd, ins;
        logic [41:0] exp;
    } vec_t;

    vec_t        tab[$];
    logic [41:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // {Op1, Op2, ALUmode, carrySelect, dest_r, reg_write_r, valid_r, illegal_r}
    function automatic logic [41:0] o(input logic [15:0] a, input logic [15:0] b,
                                      input logic [1:0] alu, input logic [1:0] cs,
                                      input logic [2:0] d, input logic rw,
                                      input logic vl, input logic il);
        return {a, b, alu, cs, d, rw, vl, il};
    endfunction

    function automatic vec_t v(input logic rst, input logic iv, input logic [15:0] ins,
                               input logic stl, input logic fl, input logic we,
                               input logic [2:0] wa, input logic [15:0] wd,
                               input logic [41:0] e);
        vec_t r;
        r.rst = rst; r.iv = iv; r.ins = ins; r.stl = stl; r.fl = fl;
        r.we = we; r.wa = wa; r.wd = wd; r.exp = e;
        return r;
    endfunction

    task automatic apply(input vec_t x, input string name);
        logic [41:0] act, e;
        @(negedge clk);
        reset = x.rst; instr_valid = x.iv; instr = x.ins; stall = x.stl;
        flush = x.fl; wb_en = x.we; wb_addr = x.wa; wb_data = x.wd;
        exp_q.push_back(x.exp);
        @(posedge clk);
        #1;
        act = {Op1, Op2, ALUmode, carrySelect, dest_r, reg_write_r, valid_r, illegal_r};
        e = exp_q.pop_front();
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got Op1=%h Op2=%h alu=%b cs=%b dst=%0d rw=%b v=%b ill=%b, want Op1=%h Op2=%h alu=%b cs=%b dst=%0d rw=%b v=%b ill=%b",
                     name, act[41:26], act[25:10], act[9:8], act[7:6], act[5:3], act[2], act[1], act[0],
                     e[41:26], e[25:10], e[9:8], e[7:6], e[5:3], e[2], e[1], e[0]);
        end
    endtask

    logic [41:0] BUB, ILL, ADD1, SETC0, IMM1234;

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = '0; stall = 1'b0;
        flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        BUB     = o(16'h0, 16'h0, 2'b11, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
        ILL     = o(16'h0, 16'h0, 2'b11, 2'b00, 3'd0, 1'b0, 1'b0, 1'b1);
        ADD1    = o(16'd15, 16'd24, 2'b00, 2'b10, 3'd3, 1'b1, 1'b1, 1'b0);
        SETC0   = o(16'h0, 16'h0, 2'b11, 2'b01, 3'd0, 1'b0, 1'b1, 1'b0);
        IMM1234 = o(16'h1234, 16'h0, 2'b10, 2'b00, 3'd6, 1'b1, 1'b1, 1'b0);

        //             rst  iv  instr    stl  fl   we   wa    wd
        tab.push_back(v(1, 0, 16'h0000, 0, 0, 0, 3'd0, 16'h0,   BUB));                  // reset
        tab.push_back(v(0, 0, 16'h0000, 0, 0, 1, 3'd1, 16'd15,  BUB));                  // R1=15
        tab.push_back(v(0, 0, 16'h0000, 0, 0, 1, 3'd2, 16'd24,  BUB));                  // R2=24
        tab.push_back(v(0, 0, 16'h0000, 0, 0, 1, 3'd5, 16'd42,  BUB));                  // R5=42
        tab.push_back(v(0, 1, 16'h3328, 0, 0, 0, 3'd0, 16'h0,   ADD1));                 // ADD R3,R1,R2
        tab.push_back(v(0, 1, 16'h1CA0, 1, 0, 0, 3'd0, 16'h0,   ADD1));                 // stall 1
        tab.push_back(v(0, 1, 16'h1CA0, 1, 0, 0, 3'd0, 16'h0,   ADD1));                 // stall 2
        tab.push_back(v(0, 1, 16'h1CA0, 0, 0, 0, 3'd0, 16'h0,
                        o(16'd42, 16'd0, 2'b01, 2'b00, 3'd4, 1, 1, 0)));                // NOT R4,R5
        tab.push_back(v(0, 1, 16'h20A0, 0, 0, 0, 3'd0, 16'h0,
                        o(16'd42, 16'd1, 2'b00, 2'b10, 3'd0, 1, 1, 0)));                // INC R0,R5
        tab.push_back(v(0, 1, 16'h2A20, 0, 0, 1, 3'd1, 16'h00AA,
                        o(16'h00AA, 16'd0, 2'b10, 2'b00, 3'd2, 1, 1, 0)));              // MOV bypass
        tab.push_back(v(0, 1, 16'h3E00, 0, 0, 0, 3'd0, 16'h0,   BUB));                  // LDM R6
        tab.push_back(v(0, 0, 16'h0000, 0, 0, 0, 3'd0, 16'h0,   BUB));                  // gap
        tab.push_back(v(0, 1, 16'h1234, 0, 0, 0, 3'd0, 16'h0,   IMM1234));              // immediate
        tab.push_back(v(0, 1, 16'h0800, 0, 0, 0, 3'd0, 16'h0,   SETC0));                // SETC
        tab.push_back(v(0, 1, 16'h3E00, 0, 0, 0, 3'd0, 16'h0,   BUB));                  // LDM R6
        tab.push_back(v(0, 1, 16'h5555, 0, 1, 0, 3'd0, 16'h0,   BUB));                  // flush in IMM
        tab.push_back(v(0, 1, 16'h0800, 0, 0, 0, 3'd0, 16'h0,   SETC0));                // SETC not imm
        tab.push_back(v(0, 1, 16'hF800, 0, 0, 0, 3'd0, 16'h0,   ILL));                  // illegal
        tab.push_back(v(0, 1, 16'h0000, 1, 0, 0, 3'd0, 16'h0,   ILL));                  // stall holds illegal
        tab.push_back(v(0, 1, 16'h0000, 0, 0, 0, 3'd0, 16'h0,
                        o(16'h0, 16'h0, 2'b11, 2'b00, 3'd0, 0, 1, 0)));                 // NOP
        tab.push_back(v(0, 1, 16'h3E00, 0, 0, 0, 3'd0, 16'h0,   BUB));                  // LDM R6
        tab.push_back(v(0, 1, 16'h1234, 1, 0, 0, 3'd0, 16'h0,   BUB));                  // stall in IMM
        tab.push_back(v(0, 1, 16'h4321, 0, 0, 0, 3'd0, 16'h0,
                        o(16'h4321, 16'h0, 2'b10, 2'b00, 3'd6, 1, 1, 0)));              // re-presented imm
        tab.push_back(v(0, 1, 16'h1000, 0, 0, 0, 3'd0, 16'h0,
                        o(16'h0, 16'h0, 2'b11, 2'b11, 3'd0, 0, 1, 0)));                 // CLRC
        tab.push_back(v(0, 0, 16'h3328, 0, 0, 0, 3'd0, 16'h0,   BUB));                  // no valid
        tab.push_back(v(0, 1, 16'h3F00, 0, 0, 0, 3'd0, 16'h0,   BUB));                  // LDM R7
        tab.push_back(v(1, 1, 16'h1234, 0, 0, 0, 3'd0, 16'h0,   BUB));                  // reset mid-LDM
        tab.push_back(v(0, 1, 16'h30F8, 0, 0, 0, 3'd0, 16'h0,
                        o(16'h0, 16'h0, 2'b00, 2'b10, 3'd0, 1, 1, 0)));                 // ADD R0,R7,R6
        tab.push_back(v(0, 1, 16'h31B0, 0, 0, 0, 3'd0, 16'h0,
                        o(16'h0, 16'h0, 2'b00, 2'b10, 3'd1, 1, 1, 0)));                 // ADD R1,R5,R4
        tab.push_back(v(0, 1, 16'h304C, 0, 0, 0, 3'd0, 16'h0,
                        o(16'h0, 16'h0, 2'b00, 2'b10, 3'd0, 1, 1, 0)));                 // ADD R0,R2,R3
        tab.push_back(v(0, 1, 16'h2A20, 0, 0, 0, 3'd0, 16'h0,
                        o(16'h0, 16'h0, 2'b10, 2'b00, 3'd2, 1, 1, 0)));                 // MOV R2,R1

        for (int i = 0; i < tab.size(); i++) begin
            apply(tab[i], $sformatf("vec%0d", i));
        end

        // Writeback during flush still lands; then read R6 and R7 back
        apply(v(0, 0, 16'h0, 0, 0, 1, 3'd7, 16'hBEEF, BUB), "wb_r7");
        apply(v(0, 1, 16'h3E00, 0, 1, 1, 3'd6, 16'h0077, BUB), "wb_during_flush");
        apply(v(0, 1, 16'h2CC0, 0, 0, 0, 3'd0, 16'h0,
                o(16'h0077, 16'h0, 2'b10, 2'b00, 3'd4, 1, 1, 0)), "mov_r4_r6");
        apply(v(0, 1, 16'h31FC, 0, 0, 0, 3'd0, 16'h0,
                o(16'hBEEF, 16'hBEEF, 2'b00, 2'b10, 3'd1, 1, 1, 0)), "add_r1_r7_r7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
